pc_gen: RTL and testbench

//  Parametrised next-generation program counter. Issues fetch addresses over a

---
 rtl/pc_gen_pkg.sv | 23 ++
 rtl/pc_gen_redirect_sel.sv | 36 +++
 rtl/pc_gen.sv | 142 ++++++++++++++
 tb/tb_pc_gen.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_gen_pkg.sv
// Shared types for the program-counter generator: FSM states and redirect sources.
// Also provides a helper that says whether a state presents a fetch request.
package pc_gen_pkg;

    typedef enum logic [1:0] {
        PC_RESET = 2'd0,
        PC_RUN   = 2'd1,
        PC_DRAIN = 2'd2,
        PC_HALT  = 2'd3
    } pc_state_e;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_JMP  = 2'd1,
        SRC_MRET = 2'd2,
        SRC_TRAP = 2'd3
    } redirect_src_e;

    function automatic logic state_fetching(input pc_state_e s);
        return (s == PC_RUN) || (s == PC_DRAIN);
    endfunction

endpackage

// File: rtl/pc_gen_redirect_sel.sv
// Combinational redirect arbiter: trap beats mret beats jump/branch.
// Produces the winning source, its target and a valid flag.
module pc_redirect_sel
    import pc_gen_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 jmp_en_i,
    input  logic [WIDTH-1:0]     jmp_target_i,
    input  logic                 trap_en_i,
    input  logic [WIDTH-1:0]     trap_vec_i,
    input  logic                 mret_en_i,
    input  logic [WIDTH-1:0]     mepc_i,
    output logic                 redirect_valid_o,
    output redirect_src_e        redirect_src_o,
    output logic [WIDTH-1:0]     redirect_target_o
);

    always_comb begin
        redirect_src_o    = SRC_NONE;
        redirect_target_o = '0;
        if (trap_en_i) begin
            redirect_src_o    = SRC_TRAP;
            redirect_target_o = trap_vec_i;
        end else if (mret_en_i) begin
            redirect_src_o    = SRC_MRET;
            redirect_target_o = mepc_i;
        end else if (jmp_en_i) begin
            redirect_src_o    = SRC_JMP;
            redirect_target_o = jmp_target_i;
        end
    end

    assign redirect_valid_o = trap_en_i | mret_en_i | jmp_en_i;

endmodule

// File: rtl/pc_gen.sv
// Program counter generator: fetch handshake, prioritised redirects, halt/resume FSM
// and saturating redirect counter. Define PC_GEN_ALIGN_CHK_EN to keep misaligned targets and flag them.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VAL   = WIDTH'(32'h8000_0000),
    parameter int               INSTR_BYTES = 4,
    parameter int               CNT_W       = 16
) (
    input  logic                clk,
    input  logic                rst,
    output logic                fetch_valid,
    input  logic                fetch_ready,
    output logic [WIDTH-1:0]    fetch_pc,
    input  logic                jmp_en,
    input  logic [WIDTH-1:0]    jmp_target,
    input  logic                trap_en,
    input  logic [WIDTH-1:0]    trap_vec,
    input  logic                mret_en,
    input  logic [WIDTH-1:0]    mepc,
    input  logic                halt_req,
    input  logic                resume_req,
    output logic                halted,
    output logic [CNT_W-1:0]    redirect_cnt,
    output logic                misalign
);

    localparam logic [WIDTH-1:0] STEP       = WIDTH'(INSTR_BYTES);
    localparam logic [WIDTH-1:0] ALIGN_MASK = ~(STEP - WIDTH'(1));

    pc_state_e          state_q, state_d;
    logic [WIDTH-1:0]   pc_q, pc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               sel_valid;
    redirect_src_e      sel_src;
    logic [WIDTH-1:0]   sel_target;
    logic               redirect;
    logic [WIDTH-1:0]   load_target;
    logic               accept;

    pc_redirect_sel #(
        .WIDTH (WIDTH)
    ) u_sel (
        .jmp_en_i          (jmp_en),
        .jmp_target_i      (jmp_target),
        .trap_en_i         (trap_en),
        .trap_vec_i        (trap_vec),
        .mret_en_i         (mret_en),
        .mepc_i            (mepc),
        .redirect_valid_o  (sel_valid),
        .redirect_src_o    (sel_src),
        .redirect_target_o (sel_target)
    );

    assign redirect    = sel_valid && (sel_src != SRC_NONE);
    assign fetch_valid = state_fetching(state_q);
    assign accept      = fetch_valid && fetch_ready;
    assign halted      = (state_q == PC_HALT);
    assign fetch_pc    = pc_q;
    assign redirect_cnt = cnt_q;

`ifdef PC_GEN_ALIGN_CHK_EN
    logic misalign_q, misalign_d;

    assign load_target = sel_target;

    always_comb begin
        misalign_d = misalign_q;
        if (redirect) begin
            misalign_d = |(sel_target & ~ALIGN_MASK);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign misalign = misalign_q;
`else
    assign load_target = sel_target & ALIGN_MASK;
    assign misalign    = 1'b0;
`endif

    // A pending request retires on accept or is squashed by a redirect; either lets a halt complete.
    always_comb begin
        state_d = state_q;
        case (state_q)
            PC_RESET: state_d = PC_RUN;
            PC_RUN: begin
                if (halt_req) begin
                    state_d = (fetch_ready || redirect) ? PC_HALT : PC_DRAIN;
                end
            end
            PC_DRAIN: begin
                if (fetch_ready || redirect) begin
                    state_d = PC_HALT;
                end
            end
            PC_HALT: begin
                if (resume_req) begin
                    state_d = PC_RUN;
                end
            end
            default: state_d = PC_RESET;
        endcase
    end

    always_comb begin
        pc_d = pc_q;
        if (redirect) begin
            pc_d = load_target;
        end else if (accept) begin
            pc_d = pc_q + STEP;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (redirect && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= PC_RESET;
            pc_q    <= RESET_VAL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed vector table, async-reset sequence,
// then randomized traffic checked against a behavioural model.
module tb_pc_gen;

`ifdef PC_GEN_ALIGN_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif
    localparam int CW = 4;
    localparam int NROW = 33;

    logic          clk = 1'b0;
    logic          rst;
    logic          fetch_valid, fetch_ready;
    logic [31:0]   fetch_pc;
    logic          jmp_en, trap_en, mret_en, halt_req, resume_req;
    logic [31:0]   jmp_target, trap_vec, mepc;
    logic          halted, misalign;
    logic [CW-1:0] redirect_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    pc_gen #(
        .WIDTH       (32),
        .RESET_VAL   (32'h8000_0000),
        .INSTR_BYTES (4),
        .CNT_W       (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .fetch_valid  (fetch_valid),
        .fetch_ready  (fetch_ready),
        .fetch_pc     (fetch_pc),
        .jmp_en       (jmp_en),
        .jmp_target   (jmp_target),
        .trap_en      (trap_en),
        .trap_vec     (trap_vec),
        .mret_en      (mret_en),
        .mepc         (mepc),
        .halt_req     (halt_req),
        .resume_req   (resume_req),
        .halted       (halted),
        .redirect_cnt (redirect_cnt),
        .misalign     (misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ready, halt, resume, trap, mret, jmp;
        logic [31:0] tv, ep, jt;
        logic [31:0] e_pc;
        logic        e_valid, e_halted;
        int          e_cnt;
        logic        e_mis;
    } vec_t;

    vec_t tbl [NROW];

    function automatic vec_t mk(input logic r, h, rs, t, m, j, input logic [31:0] tv, ep, jt,
                                input logic [31:0] epc, input logic ev, eh, input int ec, input logic em);
        vec_t v;
        v.ready = r; v.halt = h; v.resume = rs; v.trap = t; v.mret = m; v.jmp = j;
        v.tv = tv; v.ep = ep; v.jt = jt;
        v.e_pc = epc; v.e_valid = ev; v.e_halted = eh; v.e_cnt = ec; v.e_mis = em;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, h, rs, t, m, j, input logic [31:0] tv, ep, jt);
        fetch_ready = r; halt_req = h; resume_req = rs;
        trap_en = t; mret_en = m; jmp_en = j;
        trap_vec = tv; mepc = ep; jmp_target = jt;
    endtask

    // Behavioural reference: mode names and rules taken straight from the block description.
    string     m_mode;
    longint    m_pc;
    int        m_cnt;
    logic      m_mis;

    task automatic model_reset();
        m_mode = "RESET"; m_pc = 64'h8000_0000; m_cnt = 0; m_mis = 1'b0;
    endtask

    task automatic model_step();
        bit     redir;
        bit     fetching;
        longint tgt;
        redir = trap_en | mret_en | jmp_en;
        fetching = (m_mode == "RUN") || (m_mode == "DRAIN");
        tgt = trap_en ? longint'(trap_vec) : (mret_en ? longint'(mepc) : longint'(jmp_target));
        if (!CHK) tgt = tgt - (tgt % 4);
        if (redir) begin
            m_pc  = tgt;
            m_mis = CHK && (tgt % 4 != 0);
            if (m_cnt < (1 << CW) - 1) m_cnt++;
        end else if (fetching && fetch_ready) begin
            m_pc = (m_pc + 4) % (64'd1 << 32);
        end
        case (m_mode)
            "RESET": m_mode = "RUN";
            "RUN":   if (halt_req) m_mode = (fetch_ready || redir) ? "HALT" : "DRAIN";
            "DRAIN": if (fetch_ready || redir) m_mode = "HALT";
            "HALT":  if (resume_req) m_mode = "RUN";
            default: m_mode = "RESET";
        endcase
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

        tbl[0]  = mk(1,0,0,0,0,0, 0,0,0, 32'h8000_0000, 1,0, 0, 0);
        tbl[1]  = mk(1,0,0,0,0,0, 0,0,0, 32'h8000_0004, 1,0, 0, 0);
        tbl[2]  = mk(0,0,0,0,0,0, 0,0,0, 32'h8000_0004, 1,0, 0, 0);
        tbl[3]  = mk(0,0,0,0,0,0, 0,0,0, 32'h8000_0004, 1,0, 0, 0);
        tbl[4]  = mk(0,0,0,0,0,0, 0,0,0, 32'h8000_0004, 1,0, 0, 0);
        tbl[5]  = mk(0,0,0,0,0,0, 0,0,0, 32'h8000_0004, 1,0, 0, 0);
        tbl[6]  = mk(1,0,0,0,0,0, 0,0,0, 32'h8000_0008, 1,0, 0, 0);
        tbl[7]  = mk(1,0,0,1,0,1, 32'h8000_0100,0,32'h8000_0200, 32'h8000_0100, 1,0, 1, 0);
        tbl[8]  = mk(0,0,0,0,1,1, 0,32'h8000_0300,32'h8000_0400, 32'h8000_0300, 1,0, 2, 0);
        tbl[9]  = mk(0,0,0,0,0,1, 0,0,32'h8000_0200, 32'h8000_0200, 1,0, 3, 0);
        tbl[10] = mk(0,1,0,0,0,0, 0,0,0, 32'h8000_0200, 1,0, 3, 0);
        tbl[11] = mk(0,0,0,0,0,0, 0,0,0, 32'h8000_0200, 1,0, 3, 0);
        tbl[12] = mk(1,0,0,0,0,0, 0,0,0, 32'h8000_0204, 0,1, 3, 0);
        tbl[13] = mk(1,0,0,0,0,0, 0,0,0, 32'h8000_0204, 0,1, 3, 0);
        tbl[14] = mk(0,0,0,0,0,1, 0,0,32'h8000_0500, 32'h8000_0500, 0,1, 4, 0);
        tbl[15] = mk(0,1,1,0,0,0, 0,0,0, 32'h8000_0500, 1,0, 4, 0);
        tbl[16] = mk(1,1,1,0,0,0, 0,0,0, 32'h8000_0504, 0,1, 4, 0);
        tbl[17] = mk(0,0,1,0,0,0, 0,0,0, 32'h8000_0504, 1,0, 4, 0);
        tbl[18] = mk(0,1,0,0,0,1, 0,0,32'h8000_0600, 32'h8000_0600, 0,1, 5, 0);
        tbl[19] = mk(0,0,1,0,0,0, 0,0,0, 32'h8000_0600, 1,0, 5, 0);
        tbl[20] = mk(0,0,0,0,0,1, 0,0,32'hFFFF_FFFC, 32'hFFFF_FFFC, 1,0, 6, 0);
        tbl[21] = mk(1,0,0,0,0,0, 0,0,0, 32'h0000_0000, 1,0, 6, 0);
        tbl[22] = mk(0,0,0,0,0,1, 0,0,32'h8000_0102,
                     CHK ? 32'h8000_0102 : 32'h8000_0100, 1,0, 7, CHK);
        tbl[23] = mk(1,0,0,0,0,0, 0,0,0,
                     CHK ? 32'h8000_0106 : 32'h8000_0104, 1,0, 7, CHK);
        tbl[24] = mk(0,0,0,0,0,1, 0,0,32'h8000_0400, 32'h8000_0400, 1,0, 8, 0);
        for (int k = 0; k < 8; k++) begin
            tbl[25 + k] = mk(0,0,0,0,0,1, 0,0,32'h8000_1000, 32'h8000_1000, 1,0,
                             (9 + k > 15) ? 15 : 9 + k, 0);
        end

        // Reset values while rst is held
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", fetch_pc, 32'h8000_0000);
        chk("rst_valid", 32'(fetch_valid), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_cnt", 32'(redirect_cnt), 0);
        chk("rst_mis", 32'(misalign), 0);
        $display("reset: pc=%h valid=%b halted=%b cnt=%0d mis=%b",
                 fetch_pc, fetch_valid, halted, redirect_cnt, misalign);
        rst = 1'b0;
        #1;
        chk("rel_valid", 32'(fetch_valid), 0);

        for (int i = 0; i < NROW; i++) begin
            drive(tbl[i].ready, tbl[i].halt, tbl[i].resume, tbl[i].trap, tbl[i].mret,
                  tbl[i].jmp, tbl[i].tv, tbl[i].ep, tbl[i].jt);
            @(posedge clk);
            #1;
            chk($sformatf("row%0d_pc", i), fetch_pc, tbl[i].e_pc);
            chk($sformatf("row%0d_valid", i), 32'(fetch_valid), 32'(tbl[i].e_valid));
            chk($sformatf("row%0d_halted", i), 32'(halted), 32'(tbl[i].e_halted));
            chk($sformatf("row%0d_cnt", i), 32'(redirect_cnt), 32'(tbl[i].e_cnt));
            chk($sformatf("row%0d_mis", i), 32'(misalign), 32'(tbl[i].e_mis));
            $display("row %0d: pc=%h valid=%b halted=%b cnt=%0d mis=%b",
                     i, fetch_pc, fetch_valid, halted, redirect_cnt, misalign);
        end

        // Async reset in the middle of an outstanding request drops it at once
        drive(0, 0, 0, 0, 0, 1, 0, 0, 32'h8000_0700);
        @(posedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        chk("pre_arst_valid", 32'(fetch_valid), 1);
        rst = 1'b1;
        #1;
        chk("arst_pc", fetch_pc, 32'h8000_0000);
        chk("arst_valid", 32'(fetch_valid), 0);
        chk("arst_cnt", 32'(redirect_cnt), 0);
        chk("arst_halted", 32'(halted), 0);
        $display("async reset: pc=%h valid=%b cnt=%0d", fetch_pc, fetch_valid, redirect_cnt);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        for (int c = 0; c < 1500; c++) begin
            logic [31:0] r_tv, r_ep, r_jt;
            r_tv = $urandom;
            r_ep = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
            r_jt = $urandom;
            drive($urandom_range(0, 9) < 6, $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 9) == 0,
                  r_tv, r_ep, r_jt);
            @(posedge clk);
            model_step();
            #1;
            chk($sformatf("rnd%0d_pc", c), fetch_pc, 32'(m_pc));
            chk($sformatf("rnd%0d_valid", c), 32'(fetch_valid),
                32'((m_mode == "RUN") || (m_mode == "DRAIN")));
            chk($sformatf("rnd%0d_halted", c), 32'(halted), 32'(m_mode == "HALT"));
            chk($sformatf("rnd%0d_cnt", c), 32'(redirect_cnt), 32'(m_cnt));
            chk($sformatf("rnd%0d_mis", c), 32'(misalign), 32'(m_mis));
            $display("rnd %0d: mode=%s pc=%h valid=%b halted=%b cnt=%0d mis=%b",
                     c, m_mode, fetch_pc, fetch_valid, halted, redirect_cnt, misalign);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
